// File: rtl/pillar_pkg.sv
// Shared types and constants for the Pillar core memory path.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, requester IDs, default bus widths.
package pillar_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Requester IDs double as the value of the round-robin last_grant flag.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and RAM-side signals around the memory arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until gnt; the RAM side has none.
// Modports: slave = arbiter side, master = requesters plus RAM model.
interface mem_arbiter_if
    import pillar_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // Fetch requester (read-only)
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    // Load/store requester
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;

    // Single synchronous RAM port
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_we_o, mem_addr_o, mem_wdata_o,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o,
        input  busy_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between fetch and load/store.
// Latency: grant 1 cycle after request in IDLE; read data valid RD_LAT+2 cycles after request.
// Backpressure: requesters hold req until a one-cycle gnt; IDLE always separates transactions.
// Ports: clk, reset (sync, active-low), bus (mem_arbiter_if.slave: requesters + RAM port).
module mem_arbiter
    import pillar_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1            // legal range 1..4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t state;
    logic       last_grant;             // requester granted most recently
    logic       owner;                  // requester owning the current transaction
    logic       op_we;                  // current transaction is a write
    logic [2:0] wait_cnt;
    logic       pick;                   // winner if a transaction starts this cycle
    logic       pick_we;

    // A lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        pick = REQ_IF;
        if (bus.if_req_i && bus.d_req_i) begin
            pick = ~last_grant;
        end else if (bus.d_req_i) begin
            pick = REQ_D;
        end
        pick_we = (pick == REQ_D) && bus.d_we_i;
    end

    // All outputs are registered: each transition loads the values the
    // destination state presents on the next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            last_grant      <= REQ_D;
            owner           <= REQ_IF;
            op_we           <= 1'b0;
            wait_cnt        <= '0;
            bus.if_gnt_o    <= 1'b0;
            bus.if_rvalid_o <= 1'b0;
            bus.if_rdata_o  <= '0;
            bus.d_gnt_o     <= 1'b0;
            bus.d_rvalid_o  <= 1'b0;
            bus.d_rdata_o   <= '0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.busy_o      <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            bus.if_gnt_o    <= 1'b0;
            bus.d_gnt_o     <= 1'b0;
            bus.if_rvalid_o <= 1'b0;
            bus.d_rvalid_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.if_req_i || bus.d_req_i) begin
                        owner           <= pick;
                        op_we           <= pick_we;
                        bus.mem_addr_o  <= (pick == REQ_D) ? bus.d_addr_i : bus.if_addr_i;
                        bus.mem_we_o    <= pick_we;
                        bus.mem_wdata_o <= pick_we ? bus.d_wdata_i : '0;
                        bus.if_gnt_o    <= (pick == REQ_IF);
                        bus.d_gnt_o     <= (pick == REQ_D);
                        bus.busy_o      <= 1'b1;
                        state           <= ISSUE;
                    end
                end

                ISSUE: begin
                    last_grant      <= owner;
                    bus.mem_we_o    <= 1'b0;
                    bus.mem_wdata_o <= '0;
                    if (op_we) begin
                        bus.mem_addr_o <= '0;
                        bus.busy_o     <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        // Address stays on the port through WAIT.
                        wait_cnt <= 3'(RD_LAT - 1);
                        state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        if (owner == REQ_D) begin
                            bus.d_rdata_o  <= bus.mem_rdata_i;
                            bus.d_rvalid_o <= 1'b1;
                        end else begin
                            bus.if_rdata_o  <= bus.mem_rdata_i;
                            bus.if_rvalid_o <= 1'b1;
                        end
                        bus.mem_addr_o <= '0;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                RESP: begin
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) see identical traffic.
// Each instance has a transaction-timeline model checked every cycle plus literal expectations.
module tb_mem_arbiter;
    import pillar_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM contents as seen by reads.
    function automatic logic [DW-1:0] ram_val(logic [AW-1:0] a);
        case (a)
            32'h0000_0010: ram_val = 32'h0000_0013;
            32'h0000_0080: ram_val = 32'h1234_5678;
            default:       ram_val = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : 3;

        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // RAM: data at cycle c reflects the address presented at c-LAT.
        logic [AW-1:0] hist [4];
        always @(posedge clk) begin
            hist[0] <= bus.mem_addr_o;
            for (int k = 1; k < 4; k++) hist[k] <= hist[k-1];
        end
        assign bus.mem_rdata_i = ram_val(hist[LAT-1]);

        // Requesters: present queue heads, retire on grant.
        txn_t if_q[$];
        txn_t d_q[$];
        always @(posedge clk) begin
            #1;
            if (reset === 1'b0) begin
                if_q.delete();
                d_q.delete();
            end else begin
                if (bus.if_gnt_o && if_q.size() > 0) void'(if_q.pop_front());
                if (bus.d_gnt_o && d_q.size() > 0) void'(d_q.pop_front());
            end
            bus.if_req_i  = (if_q.size() > 0);
            bus.if_addr_i = (if_q.size() > 0) ? if_q[0].addr : '0;
            bus.d_req_i   = (d_q.size() > 0);
            bus.d_we_i    = (d_q.size() > 0) ? d_q[0].we : 1'b0;
            bus.d_addr_i  = (d_q.size() > 0) ? d_q[0].addr : '0;
            bus.d_wdata_i = (d_q.size() > 0) ? d_q[0].wdata : '0;
        end

        // Model: a transaction sampled at cycle t0 has fixed events at offsets from t0.
        bit            started = 0;
        bit            active = 0;
        int            t0, k, len;
        logic          m_who, m_we, m_last;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        logic [DW-1:0] m_rd [2];
        logic [1:0]    e_gnt, e_rv;
        logic          e_we, e_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;

        // Event logs for literal expectations.
        int            gcyc[$];
        logic          gwho[$];
        int            rv_cnt [2];
        int            rv_cyc [2];
        logic [DW-1:0] rv_dat [2];
        int            we_cnt, addr_cyc;
        logic [DW-1:0] we_dat;

        always @(negedge clk) begin
            if (started) begin
                e_gnt = 2'b00; e_rv = 2'b00; e_we = 1'b0; e_busy = 1'b0;
                e_addr = '0; e_wd = '0;
                if (active) begin
                    k   = cyc - t0;
                    len = m_we ? 2 : LAT + 3;
                    if (k == 1) begin
                        e_gnt[m_who] = 1'b1;
                        e_we = m_we;
                        e_wd = m_we ? m_wdata : '0;
                    end
                    if (k >= 1 && k <= (m_we ? 1 : LAT + 1)) e_addr = m_addr;
                    if (!m_we && k == LAT + 2) begin
                        m_rd[m_who] = ram_val(m_addr);
                        e_rv[m_who] = 1'b1;
                    end
                    e_busy = (k >= 1 && k < len);
                    if (k >= len) active = 0;
                end
                chk($sformatf("L%0d_if_gnt", LAT), bus.if_gnt_o, e_gnt[0]);
                chk($sformatf("L%0d_d_gnt", LAT), bus.d_gnt_o, e_gnt[1]);
                chk($sformatf("L%0d_if_rvalid", LAT), bus.if_rvalid_o, e_rv[0]);
                chk($sformatf("L%0d_d_rvalid", LAT), bus.d_rvalid_o, e_rv[1]);
                chk($sformatf("L%0d_if_rdata", LAT), bus.if_rdata_o, m_rd[0]);
                chk($sformatf("L%0d_d_rdata", LAT), bus.d_rdata_o, m_rd[1]);
                chk($sformatf("L%0d_mem_we", LAT), bus.mem_we_o, e_we);
                chk($sformatf("L%0d_mem_addr", LAT), bus.mem_addr_o, e_addr);
                chk($sformatf("L%0d_mem_wdata", LAT), bus.mem_wdata_o, e_wd);
                chk($sformatf("L%0d_busy", LAT), bus.busy_o, e_busy);
            end

            if (bus.if_gnt_o === 1'b1) begin gcyc.push_back(cyc); gwho.push_back(REQ_IF); end
            if (bus.d_gnt_o === 1'b1) begin gcyc.push_back(cyc); gwho.push_back(REQ_D); end
            if (bus.if_rvalid_o === 1'b1) begin rv_cnt[0]++; rv_cyc[0] = cyc; rv_dat[0] = bus.if_rdata_o; end
            if (bus.d_rvalid_o === 1'b1) begin rv_cnt[1]++; rv_cyc[1] = cyc; rv_dat[1] = bus.d_rdata_o; end
            if (bus.mem_we_o === 1'b1) begin we_cnt++; we_dat = bus.mem_wdata_o; end
            if (bus.mem_addr_o !== '0 && bus.mem_addr_o !== 'x) addr_cyc++;

            if (reset === 1'b0) begin
                started = 1; active = 0; m_last = REQ_D;
                m_rd[0] = '0; m_rd[1] = '0;
            end else if (started && !active && (bus.if_req_i || bus.d_req_i)) begin
                m_who   = (bus.if_req_i && bus.d_req_i) ? ~m_last : bus.d_req_i;
                m_last  = m_who;
                m_we    = m_who ? bus.d_we_i : 1'b0;
                m_addr  = m_who ? bus.d_addr_i : bus.if_addr_i;
                m_wdata = bus.d_wdata_i;
                t0      = cyc;
                active  = 1;
            end
        end
    end

    task automatic clear_logs();
        gi[0].gcyc.delete(); gi[0].gwho.delete();
        gi[1].gcyc.delete(); gi[1].gwho.delete();
        gi[0].rv_cnt[0] = 0; gi[0].rv_cnt[1] = 0; gi[1].rv_cnt[0] = 0; gi[1].rv_cnt[1] = 0;
        gi[0].we_cnt = 0; gi[1].we_cnt = 0; gi[0].addr_cyc = 0; gi[1].addr_cyc = 0;
    endtask

    task automatic push_if(logic [AW-1:0] a);
        txn_t t;
        t.addr = a; t.we = 1'b0; t.wdata = '0;
        gi[0].if_q.push_back(t); gi[1].if_q.push_back(t);
    endtask

    task automatic push_d(logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
        txn_t t;
        t.addr = a; t.we = we; t.wdata = wd;
        gi[0].d_q.push_back(t); gi[1].d_q.push_back(t);
    endtask

    task automatic wait_idle(string tag);
        int  n = 0;
        bit  done = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            done = gi[0].if_q.size() == 0 && gi[0].d_q.size() == 0 &&
                   gi[1].if_q.size() == 0 && gi[1].d_q.size() == 0 &&
                   !gi[0].bus.busy_o && !gi[1].bus.busy_o &&
                   !gi[0].bus.if_req_i && !gi[0].bus.d_req_i &&
                   !gi[1].bus.if_req_i && !gi[1].bus.d_req_i;
        end
        chk({tag, "_idle_timeout"}, done, 1'b1);
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        @(posedge clk); #2 reset = 1'b0;
        repeat (n) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        int n;
        int rv_before;

        // Reset state
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", gi[0].bus.busy_o, 1'b0);
        chk("rst_if_rdata", gi[0].bus.if_rdata_o, 32'h0);
        chk("rst_mem_addr", gi[1].bus.mem_addr_o, 32'h0);

        // Fetch read alone
        clear_logs();
        @(posedge clk); #2 push_if(32'h10);
        wait_idle("if_rd");
        chk("if_rd_ngnt", gi[0].gcyc.size(), 1);
        chk("if_rd_who", gi[0].gwho[0], REQ_IF);
        chk("if_rd_lat1", gi[0].rv_cyc[0] - gi[0].gcyc[0], 2);
        chk("if_rd_data", gi[0].rv_dat[0], 32'h13);
        chk("if_rd_addr_cyc", gi[0].addr_cyc, 2);
        chk("if_rd_no_drv", gi[0].rv_cnt[1], 0);
        chk("if_rd_lat3", gi[1].rv_cyc[0] - gi[1].gcyc[0], 4);

        // Data write
        clear_logs();
        @(posedge clk); #2 push_d(1'b1, 32'h40, 32'hDEAD_BEEF);
        wait_idle("d_wr");
        chk("d_wr_who", gi[0].gwho[0], REQ_D);
        chk("d_wr_we_cnt", gi[0].we_cnt, 1);
        chk("d_wr_wdata", gi[0].we_dat, 32'hDEAD_BEEF);
        chk("d_wr_addr_cyc", gi[1].addr_cyc, 1);
        chk("d_wr_no_rv", gi[0].rv_cnt[0] + gi[0].rv_cnt[1], 0);

        // Data read 0x80
        clear_logs();
        @(posedge clk); #2 push_d(1'b0, 32'h80, 32'h0);
        wait_idle("d_rd");
        chk("d_rd_lat3", gi[1].rv_cyc[1] - gi[1].gcyc[0], 4);
        chk("d_rd_data3", gi[1].rv_dat[1], 32'h1234_5678);
        chk("d_rd_addr_cyc3", gi[1].addr_cyc, 4);
        chk("d_rd_addr_cyc1", gi[0].addr_cyc, 2);

        // Both requesting continuously from reset
        do_reset(2);
        clear_logs();
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) begin
            push_if(32'h100 + 32'(i * 4));
            push_d(1'b0, 32'h200 + 32'(i * 4), 32'h0);
        end
        wait_idle("rr");
        chk("rr_ngnt", gi[0].gcyc.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_who%0d", i), gi[0].gwho[i], (i % 2 == 0) ? REQ_IF : REQ_D);
        end
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("rr_gap%0d", i), gi[0].gcyc[i] - gi[0].gcyc[i-1], 4);
        end
        chk("rr_gap_lat3", gi[1].gcyc[1] - gi[1].gcyc[0], 6);

        // Reset during WAIT
        clear_logs();
        @(posedge clk); #2 push_d(1'b0, 32'h300, 32'h0);
        n = 0;
        while (gi[1].bus.d_gnt_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("rw_gnt_seen", n < 50, 1'b1);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("rw_busy", gi[1].bus.busy_o, 1'b0);
        chk("rw_addr", gi[1].bus.mem_addr_o, 32'h0);
        chk("rw_rdata", gi[1].bus.d_rdata_o, 32'h0);
        repeat (8) @(negedge clk);
        chk("rw_no_rv1", gi[0].rv_cnt[1], 0);
        chk("rw_no_rv3", gi[1].rv_cnt[1], 0);
        rv_before = gi[0].gcyc.size();
        @(posedge clk); #2;
        push_if(32'h500);
        push_d(1'b0, 32'h600, 32'h0);
        wait_idle("rw_tie");
        chk("rw_tie_who", gi[0].gwho[rv_before], REQ_IF);
        chk("rw_tie_who3", gi[1].gwho[rv_before], REQ_IF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single synchronous RAM port between the instruction-fetch path and the load/store data path of the Pillar core. Each requester issues a request/grant transaction; the arbiter drives the RAM address, write enable and write data, waits the RAM read latency, and returns read data with a one-cycle valid pulse. When both requesters contend, the arbiter alternates between them so neither starves. It sits between the control unit and the RAM, replacing direct RAM drive by the control unit.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, RAM read latency in cycles, from first address cycle to data valid; legal range 1..4

- clk  in  1  clock; all logic on posedge
- reset  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch read request; must be held with if_addr_i stable until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  one-cycle grant pulse to fetch
- if_rvalid_o  out  1  one-cycle fetch read-data valid
- if_rdata_o  out  DATA_W  fetch read data, meaningful only with if_rvalid_o
- d_req_i  in  1  data request; held with d_we_i, d_addr_i and d_wdata_i stable until d_gnt_o
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_gnt_o  out  1  one-cycle grant pulse to data path
- d_rvalid_o  out  1  one-cycle data read valid; never asserted for writes
- d_rdata_o  out  DATA_W  data read data
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM address
- mem_wdata_o  out  DATA_W  RAM write data
- mem_rdata_i  in  DATA_W  RAM read data
- busy_o  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states:
  - IDLE: evaluate requests only in this state. If a request is present, register the winner, its address, write enable and write data, then go to ISSUE.
  - ISSUE: 1 cycle. Drive mem_addr_o, plus mem_we_o and mem_wdata_o for a write. Assert the winner's gnt_o. A write then returns to IDLE; a read goes to WAIT.
  - WAIT: RD_LAT cycles. Hold mem_addr_o and count down. On the last WAIT cycle, capture mem_rdata_i into the winner's rdata register, then go to RESP.
  - RESP: 1 cycle. Assert the winner's rvalid_o, then go to IDLE.
- Arbitration:
  - A single requester wins.
  - If both request, the requester not granted last wins.
  - last_grant updates in ISSUE.
- Fetch is read-only.
- Outputs outside ISSUE/WAIT: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- mem_we_o is high only in ISSUE of a write.
- rdata outputs hold their last captured value until the next capture.
- A requester that drops req before its grant is a protocol violation. The arbiter does not re-check; the transaction completes anyway.
- Wait counter is 3 bits, loaded with RD_LAT-1 on entry to WAIT.

## Timing
- Reset values:
  - all outputs 0, including rdata registers
  - state IDLE
  - last_grant = data, so fetch wins the first tie
- Reset asserted mid-transaction:
  - next cycle is IDLE with all outputs 0
  - an in-flight read is dropped; no rvalid is issued
- Read, request sampled at cycle t in IDLE:
  - gnt and address at t+1
  - mem_rdata_i sampled at t+1+RD_LAT
  - rvalid at t+2+RD_LAT
  - back in IDLE at t+3+RD_LAT
  - occupancy RD_LAT+3 cycles
- Write, request sampled at t:
  - gnt, mem_we_o and address at t+1
  - IDLE at t+2
  - occupancy 2 cycles
- A request raised during RESP or ISSUE is sampled in the next IDLE cycle.
- No back-to-back grants: IDLE always separates transactions.

## Structure
- Shared package pillar_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP)
  - requester-ID constants (REQ_IF, REQ_D)
  - ADDR_W/DATA_W defaults
- No sub-module. The round-robin choice is a one-bit last_grant flag and the latency counter is inline; neither justifies a separate module.

## Test plan
- Fetch read alone, RD_LAT=1, mem returns 0x00000013 for addr 0x10: if_gnt_o at t+1, mem_addr_o=0x10 on t+1..t+2, if_rvalid_o with 0x00000013 at t+3, d_rvalid_o stays 0.
- Data write of 0xDEADBEEF to 0x40: d_gnt_o, mem_we_o=1, mem_addr_o=0x40, mem_wdata_o=0xDEADBEEF all at t+1 only; busy_o low at t+2; no rvalid.
- Both requesting continuously (reads) from reset: grant order IF, D, IF, D; each read occupies 4 cycles.
- RD_LAT=3, data read of 0x80 returning 0x12345678: mem_addr_o held 4 cycles, d_rvalid_o at t+5 with 0x12345678.
- Reset asserted during WAIT: next cycle state IDLE, all outputs 0, no rvalid ever issued for that read; subsequent fetch wins the tie.
